sram_pixel_streamer: RTL

//  Pre-fetches one frame of 16-bit pixels from the SRAM controller (single-outstanding read handshake) into an

---
 rtl/sram_pixel_streamer.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_pixel_streamer.sv
// -----------------------------------------------------------------------------
// sram_pixel_streamer
//
// Pre-fetches one frame of pixel words from the SRAM controller read port into
// a small FIFO. It serves them to the display request side at one word per
// request. The SRAM side uses a single-outstanding read handshake. A word
// counter, not an address compare, detects the end of the frame, so the frame
// may wrap around the top of the address space.
//
// Optional feature macro: PIX_STREAM_UFLOW_CNT_EN
//   When defined, adds o_underflow_cnt. This is a saturating count of
//   o_underflow pulses. Reset and i_frame_start clear it.
//
// Ports
//   i_clk            pixel clock
//   i_rst_n          asynchronous active-low reset
//   i_enable         allow new SRAM reads; an in-flight read always completes
//   i_frame_start    1-cycle pulse: flush FIFO, restart fetch at BASE_ADDR
//   o_sram_read      1-cycle read request
//   o_sram_addr      read address, held until the read returns
//   i_sram_valid     1-cycle pulse: i_sram_data carries the pending read
//   i_sram_data      read data
//   i_pix_req        consumer asks for one pixel this cycle
//   o_pix_data       pixel word, registered, one cycle after the request
//   o_pix_valid      o_pix_data holds a real FIFO word
//   o_underflow      1-cycle pulse: a request found the FIFO empty
//   o_frame_done     1-cycle pulse in the cycle the last frame word is pushed
//   o_fifo_level     current FIFO occupancy
//   o_underflow_cnt  (optional) saturating underflow count
// -----------------------------------------------------------------------------
module sram_pixel_streamer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 480000,
  parameter int unsigned FIFO_DEPTH  = 16,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_frame_start,
  output logic              o_sram_read,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic              i_sram_valid,
  input  logic [DATA_W-1:0] i_sram_data,
  input  logic              i_pix_req,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  output logic              o_underflow,
  output logic              o_frame_done,
  output logic [LVL_W-1:0]  o_fifo_level
`ifdef PIX_STREAM_UFLOW_CNT_EN
  ,
  output logic [15:0]       o_underflow_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Fetch control state
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              inflight_q, inflight_d;
  logic              stale_q, stale_d;

  // FIFO state
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Pixel output registers
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              underflow_q, underflow_d;

  logic last_word;
  logic push_req;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic room;

  assign last_word = (wcnt_q == CNT_W'(FRAME_WORDS - 1));
  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty     = (level_q == '0);

  // Data is only accepted in WAIT. A valid during ISSUE is ignored. A valid
  // while idle can only belong to a stale read, and that read is dropped.
  assign push_req  = (state_q == S_WAIT) && i_sram_valid && !i_frame_start;
  assign push      = push_req && !full;
  assign pop       = i_pix_req && !empty && !i_frame_start;

  // Count the in-flight read against capacity, so the returning word always
  // has a free slot.
  assign room = ({1'b0, level_q} + {{LVL_W{1'b0}}, inflight_q})
                < (LVL_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Fetch FSM: next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wcnt_d       = wcnt_q;
    inflight_d   = inflight_q;
    stale_d      = stale_q;
    o_frame_done = 1'b0;

    // The abandoned read has now returned, so fetching may resume.
    if (stale_q && i_sram_valid) begin
      stale_d = 1'b0;
    end

    if (i_frame_start) begin
      state_d    = S_IDLE;
      addr_d     = BASE;
      wcnt_d     = '0;
      inflight_d = 1'b0;
      // A read issued this cycle, or one still outstanding in WAIT, will
      // return later. Remember it so its data is not mistaken for word 0.
      if ((state_q == S_ISSUE) || ((state_q == S_WAIT) && !i_sram_valid)) begin
        stale_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_enable && !stale_q && room) begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          inflight_d = 1'b1;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (i_sram_valid) begin
            inflight_d = 1'b0;
            if (last_word) begin
              o_frame_done = 1'b1;
              state_d      = S_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              wcnt_d  = wcnt_q + CNT_W'(1);
              state_d = S_IDLE;
            end
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign o_sram_read = (state_q == S_ISSUE);
  assign o_sram_addr = addr_q;

  // ---------------------------------------------------------------------------
  // FIFO pointers, level and pixel output next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    underflow_d = 1'b0;

    if (i_frame_start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      pix_data_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase

      // The pop decision uses the pre-push level. A word arriving in the
      // same cycle as a request on an empty FIFO is not bypassed.
      if (i_pix_req) begin
        if (!empty) begin
          pix_data_d  = mem_q[rd_ptr_q];
          pix_valid_d = 1'b1;
        end else begin
          pix_data_d  = '0;
          underflow_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE;
      wcnt_q      <= '0;
      inflight_q  <= 1'b0;
      stale_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      inflight_q  <= inflight_d;
      stale_q     <= stale_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      underflow_q <= underflow_d;
    end
  end

  // FIFO storage is data only and needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_sram_data;
    end
  end

  assign o_pix_data   = pix_data_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_underflow  = underflow_q;
  assign o_fifo_level = level_q;

`ifdef PIX_STREAM_UFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Increment on the same edge that raises o_underflow, so the count and
  // the pulse appear together.
  always_comb begin
    ucnt_d = ucnt_q;
    if (i_frame_start) begin
      ucnt_d = '0;
    end else if (underflow_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign o_underflow_cnt = ucnt_q;
`endif

  // Capacity gating should make a push into a full FIFO impossible.
  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push_req && full));

endmodule
